// File: rtl/branch_resolve.sv
// EX-stage branch/jump resolution: evaluates the condition, computes the target,
// and runs the fetch-redirect handshake followed by a one-cycle front-end flush.
module branch_resolve #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid,
  output logic            ex_ready,
  input  logic [2:0]      jump_i,
  input  logic            jalr_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic [XLEN-1:0] imm_i,
  output logic            redirect_valid,
  input  logic            redirect_ready,
  output logic [XLEN-1:0] redirect_pc,
  output logic            flush_o,
  output logic            link_valid,
  output logic [XLEN-1:0] link_data,
  output logic            misalign_o,
  output logic [15:0]     taken_cnt
);

  typedef enum logic [1:0] {IDLE, REDIRECT, FLUSH} state_t;

  localparam logic [XLEN-1:0] BIT0_CLR = ~{{(XLEN-1){1'b0}}, 1'b1};

  state_t          state;
  logic            accept;
  logic            taken;
  logic            is_jump;
  logic [XLEN-1:0] target;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid && ex_ready;
  assign is_jump  = (jump_i == 3'd7);

  always_comb begin
    taken = 1'b0;
    case (jump_i)
      3'd1:    taken = (rs1_i == rs2_i);
      3'd2:    taken = (rs1_i != rs2_i);
      3'd3:    taken = ($signed(rs1_i) <  $signed(rs2_i));
      3'd4:    taken = ($signed(rs1_i) >= $signed(rs2_i));
      3'd5:    taken = (rs1_i <  rs2_i);
      3'd6:    taken = (rs1_i >= rs2_i);
      3'd7:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  // jalr reads rs1_i as presented, so rd==rs1 sees the pre-write value
  always_comb begin
    target = pc_i + imm_i;
    if (is_jump && jalr_i)
      target = (rs1_i + imm_i) & BIT0_CLR;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      flush_o        <= 1'b0;
      link_valid     <= 1'b0;
      link_data      <= '0;
      misalign_o     <= 1'b0;
      taken_cnt      <= '0;
    end else begin
      link_valid <= 1'b0;
      misalign_o <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && taken) begin
            if (target[1:0] == 2'b00) begin
              state          <= REDIRECT;
              redirect_valid <= 1'b1;
              flush_o        <= 1'b1;
              redirect_pc    <= target;
              taken_cnt      <= taken_cnt + 16'd1;
              if (is_jump) begin
                link_valid <= 1'b1;
                link_data  <= pc_i + XLEN'(4);
              end
            end else begin
              misalign_o <= 1'b1;
            end
          end
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= FLUSH;
            redirect_valid <= 1'b0;
          end
        end
        FLUSH: begin
          state   <= IDLE;
          flush_o <= 1'b0;
        end
        default: begin
          state          <= IDLE;
          redirect_valid <= 1'b0;
          flush_o        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Directed vector bench for branch_resolve: table of ops plus hand sequences
// for redirect stall, reset mid-handshake and counter wrap.
module tb_branch_resolve;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [2:0]  jump_i;
  logic        jalr_i;
  logic [31:0] pc_i, rs1_i, rs2_i, imm_i;
  logic        redirect_valid;
  logic        redirect_ready;
  logic [31:0] redirect_pc;
  logic        flush_o;
  logic        link_valid;
  logic [31:0] link_data;
  logic        misalign_o;
  logic [15:0] taken_cnt;

  int errors = 0;
  int checks = 0;
  logic [15:0] cnt_exp = '0;

  always #5 clk = ~clk;

  branch_resolve #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .jump_i(jump_i), .jalr_i(jalr_i), .pc_i(pc_i), .rs1_i(rs1_i),
    .rs2_i(rs2_i), .imm_i(imm_i), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc),
    .flush_o(flush_o), .link_valid(link_valid), .link_data(link_data),
    .misalign_o(misalign_o), .taken_cnt(taken_cnt)
  );

  typedef struct {
    string       name;
    logic [2:0]  jump;
    logic        jalr;
    logic [31:0] pc, rs1, rs2, imm;
    logic        redir;
    logic [31:0] tgt;
    logic        link;
    logic [31:0] ldata;
    logic        mis;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    jump_i = v.jump; jalr_i = v.jalr; pc_i = v.pc;
    rs1_i = v.rs1; rs2_i = v.rs2; imm_i = v.imm;
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    drive(v);
    ex_valid = 1'b1;
    redirect_ready = 1'b0;
    chk({v.name, " ex_ready pre"}, 32'(ex_ready), 32'd1);
    @(negedge clk);
    ex_valid = 1'b0;
    chk({v.name, " redirect_valid"}, 32'(redirect_valid), 32'(v.redir));
    chk({v.name, " flush"}, 32'(flush_o), 32'(v.redir));
    chk({v.name, " misalign"}, 32'(misalign_o), 32'(v.mis));
    chk({v.name, " link_valid"}, 32'(link_valid), 32'(v.link));
    if (v.link) chk({v.name, " link_data"}, link_data, v.ldata);
    if (v.redir) begin
      cnt_exp++;
      chk({v.name, " redirect_pc"}, redirect_pc, v.tgt);
      chk({v.name, " ex_ready busy"}, 32'(ex_ready), 32'd0);
      redirect_ready = 1'b1;
      @(negedge clk);
      redirect_ready = 1'b0;
      chk({v.name, " flush stage rv"}, 32'(redirect_valid), 32'd0);
      chk({v.name, " flush stage fl"}, 32'(flush_o), 32'd1);
      chk({v.name, " flush stage rdy"}, 32'(ex_ready), 32'd0);
      chk({v.name, " flush stage lv"}, 32'(link_valid), 32'd0);
      @(negedge clk);
      chk({v.name, " idle flush"}, 32'(flush_o), 32'd0);
      chk({v.name, " idle ready"}, 32'(ex_ready), 32'd1);
    end else begin
      chk({v.name, " ex_ready idle"}, 32'(ex_ready), 32'd1);
      @(negedge clk);
      chk({v.name, " misalign pulse end"}, 32'(misalign_o), 32'd0);
    end
    chk({v.name, " taken_cnt"}, 32'(taken_cnt), 32'(cnt_exp));
  endtask

  initial begin
    //          name         jmp jalr pc            rs1           rs2           imm           redir tgt           link ldata         mis
    vecs[0]  = '{"beq_t",    3'd1, 0, 32'h100,      32'd5,        32'd5,        32'h20,       1, 32'h120,       0, 32'h0,         0};
    vecs[1]  = '{"bne_nt",   3'd2, 0, 32'h100,      32'd5,        32'd5,        32'h20,       0, 32'h0,         0, 32'h0,         0};
    vecs[2]  = '{"blt_t",    3'd3, 0, 32'h200,      32'hFFFFFFFF, 32'd1,        32'h10,       1, 32'h210,       0, 32'h0,         0};
    vecs[3]  = '{"bltu_nt",  3'd5, 0, 32'h200,      32'hFFFFFFFF, 32'd1,        32'h10,       0, 32'h0,         0, 32'h0,         0};
    vecs[4]  = '{"bge_t",    3'd4, 0, 32'h300,      32'd1,        32'hFFFFFFFF, 32'hFFFFFFFC, 1, 32'h2FC,       0, 32'h0,         0};
    vecs[5]  = '{"bgeu_t",   3'd6, 0, 32'h0,        32'hFFFFFFFF, 32'd1,        32'h8,        1, 32'h8,         0, 32'h0,         0};
    vecs[6]  = '{"jalr_t",   3'd7, 1, 32'h40,       32'h203,      32'h0,        32'h1,        1, 32'h204,       1, 32'h44,        0};
    vecs[7]  = '{"jalr_mis", 3'd7, 1, 32'h40,       32'h203,      32'h0,        32'h0,        0, 32'h0,         0, 32'h0,         1};
    vecs[8]  = '{"jal_t",    3'd7, 0, 32'h1000,     32'h3,        32'h0,        32'h800,      1, 32'h1800,      1, 32'h1004,      0};
    vecs[9]  = '{"beq_mis",  3'd1, 0, 32'h100,      32'd7,        32'd7,        32'h2,        0, 32'h0,         0, 32'h0,         1};
    vecs[10] = '{"none",     3'd0, 1, 32'h100,      32'd7,        32'd7,        32'h20,       0, 32'h0,         0, 32'h0,         0};
    vecs[11] = '{"jal_wrap", 3'd7, 0, 32'hFFFFFFFC, 32'h0,        32'h0,        32'h8,        1, 32'h4,         1, 32'h0,         0};
    vecs[12] = '{"bne_t",    3'd2, 0, 32'h10,       32'd1,        32'd2,        32'hFFFFFFF0, 1, 32'h0,         0, 32'h0,         0};

    rst = 1'b1; ex_valid = 1'b0; redirect_ready = 1'b0;
    jump_i = '0; jalr_i = 1'b0; pc_i = '0; rs1_i = '0; rs2_i = '0; imm_i = '0;
    repeat (2) @(negedge clk);
    chk("rst redirect_valid", 32'(redirect_valid), 32'd0);
    chk("rst redirect_pc", redirect_pc, 32'd0);
    chk("rst flush", 32'(flush_o), 32'd0);
    chk("rst link_valid", 32'(link_valid), 32'd0);
    chk("rst link_data", link_data, 32'd0);
    chk("rst misalign", 32'(misalign_o), 32'd0);
    chk("rst taken_cnt", 32'(taken_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst ex_ready", 32'(ex_ready), 32'd1);

    // redirect_ready high while idle must do nothing
    redirect_ready = 1'b1;
    @(negedge clk);
    chk("idle rdy rv", 32'(redirect_valid), 32'd0);
    chk("idle rdy fl", 32'(flush_o), 32'd0);
    redirect_ready = 1'b0;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Stall: fetch withholds ready for 5 cycles; a new op offered meanwhile is ignored
    @(negedge clk);
    drive(vecs[0]); ex_valid = 1'b1;
    @(negedge clk);
    cnt_exp++;
    drive(vecs[2]);
    for (int k = 0; k < 5; k++) begin
      chk("stall rv", 32'(redirect_valid), 32'd1);
      chk("stall pc", redirect_pc, 32'h120);
      chk("stall fl", 32'(flush_o), 32'd1);
      chk("stall rdy", 32'(ex_ready), 32'd0);
      @(negedge clk);
    end
    ex_valid = 1'b0;
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    chk("stall flush rv", 32'(redirect_valid), 32'd0);
    chk("stall flush fl", 32'(flush_o), 32'd1);
    @(negedge clk);
    chk("stall idle fl", 32'(flush_o), 32'd0);
    chk("stall idle rdy", 32'(ex_ready), 32'd1);
    chk("stall cnt", 32'(taken_cnt), 32'(cnt_exp));

    // Reset while a redirect is pending
    drive(vecs[8]); ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    chk("prerst rv", 32'(redirect_valid), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cnt_exp = '0;
    chk("midrst rv", 32'(redirect_valid), 32'd0);
    chk("midrst pc", redirect_pc, 32'd0);
    chk("midrst fl", 32'(flush_o), 32'd0);
    chk("midrst lv", 32'(link_valid), 32'd0);
    chk("midrst ld", link_data, 32'd0);
    chk("midrst cnt", 32'(taken_cnt), 32'd0);
    chk("midrst rdy", 32'(ex_ready), 32'd1);

    // Counter wrap: preload to 0xFFFF, one more taken op rolls to 0
    @(negedge clk);
    force dut.taken_cnt = 16'hFFFF;
    #1 release dut.taken_cnt;
    cnt_exp = 16'hFFFF;
    chk("preload cnt", 32'(taken_cnt), 32'hFFFF);
    run_vec(vecs[6]);
    chk("wrap cnt", 32'(taken_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
